// File: rtl/board_scan_ctrl.sv
// Board scan controller: walks the 9-way cell mux, captures the board and reports winner/draw/error.
// Optional build macro SCAN_ABORT_EN adds an abort input that cancels a scan in progress.
module board_scan_ctrl #(
    parameter int CELL_W = 16,
    parameter int SETTLE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef SCAN_ABORT_EN
    input  logic              abort,
`endif
    output logic [3:0]        sel,
    input  logic [CELL_W-1:0] cell_in,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              draw,
    output logic              err,
    output logic [7:0]        win_line
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

    localparam logic [1:0] SETTLE_C = 2'(SETTLE);
    localparam logic [3:0] LAST_IDX = 4'd8;

    state_t      state_r;
    logic [3:0]  idx_r;
    logic [1:0]  cnt_r;
    logic [17:0] board_r;
    logic        illegal_r;
    logic [3:0]  sel_r;
    logic        busy_r;
    logic        done_r;
    logic [1:0]  winner_r;
    logic        draw_r;
    logic        err_r;
    logic [7:0]  win_line_r;

    logic        abort_s;
    logic [1:0]  cell_code_s;
    logic        cell_bad_s;
    logic [7:0]  x_lines_s;
    logic [7:0]  o_lines_s;
    logic        full_s;
    logic [1:0]  res_winner_s;
    logic        res_draw_s;
    logic        res_err_s;
    logic [7:0]  res_line_s;

`ifdef SCAN_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Line bits: [0..2] rows, [3..5] columns, [6] main diagonal, [7] anti-diagonal.
    function automatic logic [7:0] line_mask(input logic [17:0] b, input logic [1:0] p);
        logic [8:0] m;
        for (int i = 0; i < 9; i++) begin
            m[i] = (b[2*i +: 2] == p);
        end
        return {m[2] & m[4] & m[6],
                m[0] & m[4] & m[8],
                m[2] & m[5] & m[8],
                m[1] & m[4] & m[7],
                m[0] & m[3] & m[6],
                m[6] & m[7] & m[8],
                m[3] & m[4] & m[5],
                m[0] & m[1] & m[2]};
    endfunction

    function automatic logic board_full(input logic [17:0] b);
        logic f;
        f = 1'b1;
        for (int i = 0; i < 9; i++) begin
            f = f & (b[2*i +: 2] != 2'd0);
        end
        return f;
    endfunction

    assign x_lines_s = line_mask(board_r, 2'd1);
    assign o_lines_s = line_mask(board_r, 2'd2);
    assign full_s    = board_full(board_r);

    // Decode the mux output into the 2-bit board encoding, flagging anything else.
    always_comb begin
        cell_code_s = 2'd0;
        cell_bad_s  = 1'b0;
        if (cell_in == CELL_W'(1)) begin
            cell_code_s = 2'd1;
        end else if (cell_in == CELL_W'(2)) begin
            cell_code_s = 2'd2;
        end else if (cell_in == {CELL_W{1'b0}}) begin
            cell_code_s = 2'd0;
        end else begin
            cell_bad_s = 1'b1;
        end
    end

    // Resolve the captured board into the reported result, errors taking precedence.
    always_comb begin
        res_winner_s = 2'd0;
        res_draw_s   = 1'b0;
        res_err_s    = 1'b0;
        res_line_s   = 8'h00;
        if (illegal_r) begin
            res_err_s = 1'b1;
        end else if ((x_lines_s != 8'h00) && (o_lines_s != 8'h00)) begin
            res_err_s  = 1'b1;
            res_line_s = x_lines_s | o_lines_s;
        end else if (x_lines_s != 8'h00) begin
            res_winner_s = 2'd1;
            res_line_s   = x_lines_s;
        end else if (o_lines_s != 8'h00) begin
            res_winner_s = 2'd2;
            res_line_s   = o_lines_s;
        end else if (full_s) begin
            res_draw_s = 1'b1;
        end else begin
            res_draw_s = 1'b0;
        end
    end

    // Scan sequencer with registered select, status and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 4'd0;
            cnt_r      <= 2'd0;
            board_r    <= 18'd0;
            illegal_r  <= 1'b0;
            sel_r      <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            winner_r   <= 2'd0;
            draw_r     <= 1'b0;
            err_r      <= 1'b0;
            win_line_r <= 8'h00;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sel_r  <= 4'd0;
                    busy_r <= 1'b0;
                    if (start && !abort_s) begin
                        state_r    <= ST_SCAN;
                        idx_r      <= 4'd0;
                        cnt_r      <= 2'd0;
                        board_r    <= 18'd0;
                        illegal_r  <= 1'b0;
                        busy_r     <= 1'b1;
                        winner_r   <= 2'd0;
                        draw_r     <= 1'b0;
                        err_r      <= 1'b0;
                        win_line_r <= 8'h00;
                    end
                end
                ST_SCAN: begin
                    if (abort_s) begin
                        state_r    <= ST_IDLE;
                        sel_r      <= 4'd0;
                        busy_r     <= 1'b0;
                        winner_r   <= 2'd0;
                        draw_r     <= 1'b0;
                        err_r      <= 1'b0;
                        win_line_r <= 8'h00;
                    end else if (cnt_r == SETTLE_C) begin
                        for (int i = 0; i < 9; i++) begin
                            if (idx_r == 4'(i)) begin
                                board_r[2*i +: 2] <= cell_code_s;
                            end
                        end
                        illegal_r <= illegal_r | cell_bad_s;
                        cnt_r     <= 2'd0;
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_EVAL;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                            sel_r <= idx_r + 4'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                ST_EVAL: begin
                    state_r <= ST_IDLE;
                    sel_r   <= 4'd0;
                    busy_r  <= 1'b0;
                    if (abort_s) begin
                        winner_r   <= 2'd0;
                        draw_r     <= 1'b0;
                        err_r      <= 1'b0;
                        win_line_r <= 8'h00;
                    end else begin
                        done_r     <= 1'b1;
                        winner_r   <= res_winner_s;
                        draw_r     <= res_draw_s;
                        err_r      <= res_err_s;
                        win_line_r <= res_line_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sel_r   <= 4'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sel      = sel_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign winner   = winner_r;
    assign draw     = draw_r;
    assign err      = err_r;
    assign win_line = win_line_r;

endmodule

// File: tb/tb_board_scan_ctrl.sv
// Directed bench for board_scan_ctrl: one instance with SETTLE=0 and one with SETTLE=2.
module tb_board_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start2, abort0, abort2;
    logic [3:0]  sel0, sel2;
    logic [15:0] cell0, cell2;
    logic        busy0, done0, draw0, err0;
    logic        busy2, done2, draw2, err2;
    logic [1:0]  winner0, winner2;
    logic [7:0]  line0, line2;
    logic [15:0] brd [0:15];

    int checks   = 0;
    int failures = 0;
    int cyc;
    int nd;

    always #5 clk = ~clk;

    assign cell0 = brd[sel0];
    assign cell2 = brd[sel2];

    board_scan_ctrl #(.CELL_W(16), .SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start0),
`ifdef SCAN_ABORT_EN
        .abort(abort0),
`endif
        .sel(sel0), .cell_in(cell0), .busy(busy0), .done(done0),
        .winner(winner0), .draw(draw0), .err(err0), .win_line(line0)
    );

    board_scan_ctrl #(.CELL_W(16), .SETTLE(2)) u2 (
        .clk(clk), .rst(rst), .start(start2),
`ifdef SCAN_ABORT_EN
        .abort(abort2),
`endif
        .sel(sel2), .cell_in(cell2), .busy(busy2), .done(done2),
        .winner(winner2), .draw(draw2), .err(err2), .win_line(line2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Nibble i (left to right) is the value of cell i.
    task automatic load(input logic [35:0] b);
        for (int i = 0; i < 9; i++) begin
            brd[i] = {12'h000, b[35-4*i -: 4]};
        end
    endtask

    task automatic count_done0(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick;
            if (done0) cnt++;
        end
    endtask

    task automatic scan0(input string tag, input logic [1:0] w, input logic d,
                         input logic e, input logic [7:0] l);
        int c;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        check({tag, "_clr"}, {winner0, draw0, err0, line0}, 12'h000);
        c = 0;
        while (!done0 && c < 100) begin
            tick;
            c++;
        end
        check({tag, "_lat"}, c, 10);
        check({tag, "_res"}, {winner0, draw0, err0, line0}, {w, d, e, l});
        tick;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) brd[i] = 16'h0000;
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; abort0 = 1'b0; abort2 = 1'b0;
        tick;
        tick;
        rst = 1'b0;

        check("rst_sel", sel0, 4'd0);
        check("rst_busy_done", {busy0, done0}, 2'b00);
        check("rst_res", {winner0, draw0, err0, line0}, 12'h000);
        check("rst2_all", {sel2, busy2, done2, winner2, draw2, err2, line2}, 19'd0);

        // Empty board: select walk and done timing
        load(36'h0_0_0_0_0_0_0_0_0);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        check("walk_busy", busy0, 1'b1);
        check("walk_sel0", sel0, 4'd0);
        for (int n = 1; n <= 8; n++) begin
            tick;
            check("walk_sel", sel0, n);
        end
        tick;
        check("walk_eval", {busy0, done0}, 2'b10);
        tick;
        check("walk_done", {busy0, done0}, 2'b01);
        check("walk_res", {winner0, draw0, err0, line0}, 12'h000);
        tick;
        check("walk_pulse", done0, 1'b0);

        // X top row, O anti-diagonal
        load(36'h1_1_1_2_2_0_0_2_0);
        scan0("xrow", 2'd1, 1'b0, 1'b0, 8'h01);
        check("xrow_hold", {winner0, line0}, {2'd1, 8'h01});
        load(36'h1_1_2_0_2_1_2_0_1);
        scan0("odiag", 2'd2, 1'b0, 1'b0, 8'h80);

        // Both players win: error with union of lines
        load(36'h1_1_1_0_0_0_2_2_2);
        scan0("both", 2'd0, 1'b0, 1'b1, 8'h05);

        // Full board draw on the SETTLE=2 instance
        load(36'h1_2_1_1_2_2_2_1_1);
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 100) begin
            tick;
            cyc++;
        end
        check("draw2_lat", cyc, 28);
        check("draw2_res", {winner2, draw2, err2, line2}, {2'd0, 1'b1, 1'b0, 8'h00});
        check("draw2_busy", busy2, 1'b0);
        load(36'h1_2_1_1_2_2_2_1_1);
        scan0("draw0", 2'd0, 1'b1, 1'b0, 8'h00);

        // Illegal cell value, with start re-asserted mid-scan
        load(36'h1_1_1_0_3_0_0_0_0);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        tick; tick; tick;
        start0 = 1'b1;
        tick; tick;
        start0 = 1'b0;
        count_done0(20, nd);
        check("ill_ndone", nd, 1);
        check("ill_res", {winner0, draw0, err0, line0}, {2'd0, 1'b0, 1'b1, 8'h00});
        check("ill_idle", busy0, 1'b0);

        // Reset during scan
        load(36'h1_1_1_0_0_0_0_0_0);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check("rstm_sel5", sel0, 4'd5);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rstm_out", {sel0, busy0, done0, winner0, draw0, err0, line0}, 19'd0);
        count_done0(15, nd);
        check("rstm_ndone", nd, 0);
        scan0("rstm_new", 2'd1, 1'b0, 1'b0, 8'h01);

`ifdef SCAN_ABORT_EN
        // Abort mid-scan, then abort together with start in IDLE
        load(36'h1_1_1_0_0_0_0_0_0);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        check("ab_sel3", sel0, 4'd3);
        abort0 = 1'b1;
        tick;
        abort0 = 1'b0;
        check("ab_out", {sel0, busy0, done0, winner0, draw0, err0, line0}, 19'd0);
        count_done0(15, nd);
        check("ab_ndone", nd, 0);
        abort0 = 1'b1;
        start0 = 1'b1;
        tick;
        abort0 = 1'b0;
        start0 = 1'b0;
        check("ab_idle_start", busy0, 1'b0);
        tick;
        check("ab_idle_start2", busy0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
